// File: rtl/scroll_text_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scroll_text_sequencer_if                                                   |
// | Control, buffer-write and segment-output bundle of the text sequencer.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface scroll_text_sequencer_if #(
  parameter int MSG_MAX = 16,
  parameter int GAP     = 1
);
  localparam int c_AW = $clog2(MSG_MAX);
  localparam int c_PW = $clog2(MSG_MAX + GAP);

  logic              tick;
  logic              run;
  logic              dir;
  logic              wr_en;
  logic [c_AW-1:0]   wr_addr;
  logic [4:0]        wr_char;
  logic              len_wr;
  logic [c_AW:0]     len_in;
  logic [31:0]       seg_bus;
  logic [c_PW-1:0]   pos;
  logic              wrap_pulse;

  modport master (
    output tick, run, dir, wr_en, wr_addr, wr_char, len_wr, len_in,
    input  seg_bus, pos, wrap_pulse
  );

  modport slave (
    input  tick, run, dir, wr_en, wr_addr, wr_char, len_wr, len_in,
    output seg_bus, pos, wrap_pulse
  );
endinterface
`default_nettype wire

// File: rtl/scroll_text_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scroll_text_sequencer                                                      |
// | Scrolls a 4-character window over a writable message buffer and emits      |
// | registered active-low seven-segment bytes for the digit scanner.           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module scroll_text_sequencer #(
  parameter int MSG_MAX    = 16,
  parameter int GAP        = 1,
  parameter int HOLD_TICKS = 2
) (
  input  wire                             clk,
  input  wire                             reset,
  scroll_text_sequencer_if.slave          bus
);
  localparam int c_AW = $clog2(MSG_MAX);
  localparam int c_LW = c_AW + 1;
  localparam int c_PW = $clog2(MSG_MAX + GAP);
  localparam int c_SW = ((c_PW > c_LW) ? c_PW : c_LW) + 1;
  localparam int c_HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  localparam logic [c_LW-1:0] c_LEN_MAX   = c_LW'(MSG_MAX);
  localparam logic [c_LW-1:0] c_WIN       = c_LW'(4);
  localparam logic [c_HW-1:0] c_HOLD_INIT = c_HW'(HOLD_TICKS);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_SCROLL = 2'd1;
  localparam logic [1:0] c_ST_HOLD   = 2'd2;

  logic [4:0]      r_buf [MSG_MAX];
  logic [c_LW-1:0] r_len;
  logic [c_PW-1:0] r_pos;
  logic [c_HW-1:0] r_hold;
  logic [1:0]      r_state;
  logic            r_wrap;
  logic [31:0]     r_seg;

  logic [c_SW-1:0] w_v;
  logic            w_short;
  logic            w_at_end;
  logic [c_PW-1:0] w_last;
  logic [31:0]     w_seg;

  function automatic logic [7:0] f_decode(input logic [4:0] code);
    case (code)
      5'd0:  f_decode = 8'h03;
      5'd1:  f_decode = 8'h9F;
      5'd2:  f_decode = 8'h25;
      5'd3:  f_decode = 8'h0D;
      5'd4:  f_decode = 8'h99;
      5'd5:  f_decode = 8'h49;
      5'd6:  f_decode = 8'h41;
      5'd7:  f_decode = 8'h1F;
      5'd8:  f_decode = 8'h01;
      5'd9:  f_decode = 8'h09;
      5'd10: f_decode = 8'h11;
      5'd11: f_decode = 8'hC1;
      5'd12: f_decode = 8'h63;
      5'd13: f_decode = 8'h85;
      5'd14: f_decode = 8'h61;
      5'd15: f_decode = 8'h71;
      5'd16: f_decode = 8'h91;
      5'd17: f_decode = 8'h9F;
      5'd18: f_decode = 8'h87;
      5'd19: f_decode = 8'hE3;
      5'd20: f_decode = 8'hD5;
      5'd21: f_decode = 8'hC5;
      5'd22: f_decode = 8'h31;
      5'd23: f_decode = 8'h49;
      5'd24: f_decode = 8'h83;
      5'd25: f_decode = 8'h25;
      5'd26: f_decode = 8'hFD;
      default: f_decode = 8'hFF;
    endcase
  endfunction

  assign w_v      = c_SW'(r_len) + c_SW'(GAP);
  assign w_short  = (r_len <= c_WIN);
  assign w_at_end = (c_SW'(r_pos) == (w_v - c_SW'(1)));
  assign w_last   = c_PW'(w_v - c_SW'(1));

  // Short messages sit still at the left; otherwise index wraps modulo len+GAP.
  for (genvar k = 0; k < 4; k++) begin : g_digit
    logic [c_SW-1:0] w_sum;
    logic [c_SW-1:0] w_idx;
    logic [4:0]      w_code;

    always_comb begin
      w_sum = c_SW'(r_pos) + c_SW'(k);
      if (w_short) begin
        w_idx = c_SW'(k);
      end else if (w_sum >= w_v) begin
        w_idx = w_sum - w_v;
      end else begin
        w_idx = w_sum;
      end
      w_code = (w_idx < c_SW'(r_len)) ? r_buf[w_idx[c_AW-1:0]] : 5'd31;
    end

    assign w_seg[(3-k)*8 +: 8] = f_decode(w_code);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSG_MAX; i++) begin
        r_buf[i] <= 5'd31;
      end
    end else if (bus.wr_en) begin
      r_buf[bus.wr_addr] <= bus.wr_char;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
      r_len   <= '0;
      r_pos   <= '0;
      r_hold  <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (bus.len_wr) begin
        // A tick in the same cycle is intentionally lost.
        r_len   <= (bus.len_in > c_LEN_MAX) ? c_LEN_MAX : bus.len_in;
        r_pos   <= '0;
        r_hold  <= '0;
        r_state <= c_ST_IDLE;
      end else begin
        case (r_state)
          c_ST_IDLE: begin
            if (bus.run && !w_short) begin
              r_state <= c_ST_SCROLL;
            end
          end
          c_ST_SCROLL: begin
            if (!bus.run || w_short) begin
              r_state <= c_ST_IDLE;
            end else if (bus.tick) begin
              if (!bus.dir) begin
                if (w_at_end) begin
                  r_pos   <= '0;
                  r_wrap  <= 1'b1;
                  r_hold  <= c_HOLD_INIT;
                  r_state <= c_ST_HOLD;
                end else begin
                  r_pos <= r_pos + 1'b1;
                end
              end else if (r_pos == '0) begin
                r_pos  <= w_last;
                r_wrap <= 1'b1;
              end else begin
                r_pos <= r_pos - 1'b1;
              end
            end
          end
          c_ST_HOLD: begin
            if (!bus.run) begin
              r_state <= c_ST_IDLE;
            end else if (bus.tick) begin
              if (r_hold <= c_HW'(1)) begin
                r_hold  <= '0;
                r_state <= c_ST_SCROLL;
              end else begin
                r_hold <= r_hold - 1'b1;
              end
            end
          end
          default: r_state <= c_ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= 32'hFFFF_FFFF;
    end else begin
      r_seg <= w_seg;
    end
  end

  assign bus.seg_bus    = r_seg;
  assign bus.pos        = r_pos;
  assign bus.wrap_pulse = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scroll_text_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_scroll_text_sequencer                                                   |
// | Directed bench for scroll_text_sequencer (MSG_MAX 16, GAP 1, HOLD 2).      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_scroll_text_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scroll_text_sequencer_if #(.MSG_MAX(16), .GAP(1)) bus ();

  scroll_text_sequencer #(
    .MSG_MAX   (16),
    .GAP       (1),
    .HOLD_TICKS(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%08h exp=%08h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input int c);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[3:0];
    bus.wr_char = c[4:0];
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic set_len(input int l);
    bus.len_wr = 1'b1;
    bus.len_in = l[4:0];
    cyc();
    bus.len_wr = 1'b0;
  endtask

  // Returns the wrap flag seen right after the stepping edge; a second edge
  // lets seg_bus catch up with the new position.
  task automatic do_tick(output logic w);
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    w = bus.wrap_pulse;
    cyc();
  endtask

  int   msg[6]     = '{1, 9, 9, 9, 2, 0};
  int   exp_pos[7] = '{1, 2, 3, 4, 5, 6, 0};
  int   saif[4]    = '{23, 10, 17, 15};
  logic w;

  initial begin
    reset       = 1'b1;
    bus.tick    = 1'b0;
    bus.run     = 1'b0;
    bus.dir     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_char = '0;
    bus.len_wr  = 1'b0;
    bus.len_in  = '0;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    check_val("rst_seg",  bus.seg_bus,    32'hFFFF_FFFF);
    check_val("rst_pos",  32'(bus.pos),   32'd0);
    check_val("rst_wrap", 32'(bus.wrap_pulse), 32'd0);

    // Four-character message never scrolls.
    for (int i = 0; i < 4; i++) wr(i, saif[i]);
    set_len(4);
    bus.run = 1'b1;
    cyc(2);
    do_tick(w);
    check_val("short_seg1", bus.seg_bus, 32'h4911_9F71);
    for (int i = 0; i < 9; i++) do_tick(w);
    check_val("short_seg10", bus.seg_bus, 32'h4911_9F71);
    check_val("short_pos10", 32'(bus.pos), 32'd0);

    // Six-character message, V = 7, scrolling left-to-right.
    for (int i = 0; i < 6; i++) wr(i, msg[i]);
    set_len(6);
    cyc();
    check_val("scr_seg0", bus.seg_bus, 32'h9F09_0909);
    for (int i = 0; i < 7; i++) begin
      do_tick(w);
      check_val($sformatf("scr_pos%0d", i + 1), 32'(bus.pos), 32'(exp_pos[i]));
      check_val($sformatf("scr_wrap%0d", i + 1), 32'(w), (i == 6) ? 32'd1 : 32'd0);
      if (i == 2) check_val("scr_seg_p3", bus.seg_bus, 32'h0925_03FF);
    end
    do_tick(w);
    check_val("hold_pos1", 32'(bus.pos), 32'd0);
    do_tick(w);
    check_val("hold_pos2", 32'(bus.pos), 32'd0);
    do_tick(w);
    check_val("hold_exit_pos", 32'(bus.pos), 32'd1);

    // Reverse direction from position 0 wraps to V-1.
    set_len(6);
    bus.dir = 1'b1;
    cyc();
    do_tick(w);
    check_val("rev_pos",  32'(bus.pos), 32'd6);
    check_val("rev_wrap", 32'(w), 32'd1);
    check_val("rev_seg",  bus.seg_bus, 32'hFF9F_0909);

    // Length load, tick and write all in one cycle.
    bus.tick    = 1'b1;
    bus.len_wr  = 1'b1;
    bus.len_in  = 5'd20;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd6;
    bus.wr_char = 5'd10;
    cyc();
    bus.tick   = 1'b0;
    bus.len_wr = 1'b0;
    bus.wr_en  = 1'b0;
    check_val("lw_pos",  32'(bus.pos), 32'd0);
    check_val("lw_wrap", 32'(bus.wrap_pulse), 32'd0);
    cyc();
    check_val("lw_seg", bus.seg_bus, 32'h9F09_0909);
    bus.dir = 1'b0;
    for (int i = 0; i < 4; i++) do_tick(w);
    check_val("lw_pos4", 32'(bus.pos), 32'd4);
    check_val("lw_seg4", bus.seg_bus, 32'h2503_11FF);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_val("async_seg",  bus.seg_bus, 32'hFFFF_FFFF);
    check_val("async_pos",  32'(bus.pos), 32'd0);
    check_val("async_wrap", 32'(bus.wrap_pulse), 32'd0);
    #2;
    reset = 1'b0;
    cyc(2);
    check_val("post_rst_seg", bus.seg_bus, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/scroll_text_sequencer.md
Name: scroll_text_sequencer

Overview:
- Upstream character source for the 4-digit multiplexed seven-segment scanner.
- Holds a writable message buffer of character codes and scrolls a 4-character window across it, one step per tick strobe from the slow clock divider.
- Emits four registered active-low segment bytes, ready for direct use as CX values by the digit scanner.
- Replaces fixed hard-coded patterns with runtime-loaded, scrolling text.

Parameters:
MSG_MAX, 16, buffer depth in characters (power of 2)
GAP, 1, blank characters appended after the message before it wraps
HOLD_TICKS, 2, ticks the window dwells at position 0 after each wrap

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous active-high reset
tick  in  1  one-cycle scroll strobe, synchronous to clk
run  in  1  1 = scrolling enabled; 0 = freeze position
dir  in  1  0 = window advances left-to-right (pos+1); 1 = pos-1
wr_en  in  1  write buf[wr_addr] <= wr_char
wr_addr  in  $clog2(MSG_MAX)  buffer write address
wr_char  in  5  character code
len_wr  in  1  load message length
len_in  in  $clog2(MSG_MAX)+1  new length, 0..MSG_MAX
seg_bus  out  32  [31:24] leftmost digit .. [7:0] rightmost; per byte bit7..bit1 = a..g, bit0 = dp; active-low
pos  out  $clog2(MSG_MAX+GAP)  current window start index
wrap_pulse  out  1  one-cycle pulse when pos wraps

Behaviour:
- Reset (async, active-high):
  - every buf entry = 31 (blank); len = 0; pos = 0; state = IDLE
  - seg_bus = 32'hFFFF_FFFF; wrap_pulse = 0; hold counter = 0
- Character decode, code -> byte (dp is always off):
  - 0-9 -> 03,9F,25,0D,99,49,41,1F,01,09
  - 10 A=11, 11 b=C1, 12 C=63, 13 d=85, 14 E=61, 15 F=71, 16 H=91, 17 I=9F, 18 J=87
  - 19 L=E3, 20 n=D5, 21 o=C5, 22 P=31, 23 S=49, 24 U=83, 25 Z=25, 26 '-'=FD
  - 27-31 blank=FF
- Window:
  - V = len+GAP.
  - Digit k (k = 0 leftmost) shows index i = (pos+k) mod V; shows blank if i >= len.
  - If len <= 4, pos is forced to 0 and V is unused: digit k shows buf[k] for k < len, else blank.
- State machine, all transitions evaluated on cycles where tick = 1 unless noted:
  - IDLE: entered when run = 0 or len <= 4; pos frozen. Goes to SCROLL when run = 1 and len > 4 (evaluated every cycle).
  - SCROLL: on tick, dir 0 steps pos+1 and wraps V-1 -> 0; dir 1 steps pos-1 and wraps 0 -> V-1. On a wrap, wrap_pulse = 1 for that cycle. A wrap landing on pos = 0 goes to HOLD with counter = HOLD_TICKS. run = 0 goes to IDLE.
  - HOLD: each tick decrements the counter; at 0 go to SCROLL with no pos change on that tick. run = 0 goes to IDLE.
- Length load:
  - len_wr has priority over tick in the same cycle.
  - len = min(len_in, MSG_MAX); pos = 0; hold counter cleared; state re-evaluated next cycle.
  - A tick coinciding with len_wr is dropped.
- Buffer writes:
  - wr_en writes buf[wr_addr] at the edge; takes effect the same cycle as a tick with no conflict.
  - wr_char is stored as-is (5 bits, any value).
- Latency:
  - seg_bus is registered and reflects the buf/len/pos values of the previous cycle.
  - Write or step at edge N -> seg_bus updated at edge N+1.
- tick while run = 0: ignored. dir change mid-scroll applies at the next tick.
- Reset mid-scroll returns all state to reset values immediately, with no clock required.

Test Plan:
- Reset, no writes -> seg_bus = FFFFFFFF, pos = 0, wrap_pulse = 0.
- Write codes 23,10,17,15 to addr 0-3, len_in = 4, run = 1, 10 ticks -> seg_bus = 4911_9F71 constant; pos stays 0.
- Write digits 1,9,9,9,2,0 (len 6, V 7), run = 1, dir = 0:
  - after each tick, pos = 1,2,3,4,5,6,0
  - at pos = 3, seg_bus = 0925_03FF
  - wrap_pulse on the 7th tick
  - next 2 ticks hold pos = 0; 3rd tick -> pos = 1
- Same message, dir = 1 from pos = 0 -> first tick gives pos = 6, seg_bus = FF9F_0909 and wrap_pulse = 1.
- Assert tick and len_wr (len_in = 20) together -> len = 16, pos = 0, tick dropped; wr_en at same cycle still writes.
- Assert reset asynchronously between clk edges during SCROLL -> seg_bus = FFFFFFFF and pos = 0 before the next clk edge.
